// File: rtl/systolic_result_drain_if.sv
// Valid/ready row-beat bus from the result drain to the output buffer.
// The drain side uses the master modport; the buffer side uses slave.
interface systolic_result_drain_if #(
  parameter int N_ROWS = 16,
  parameter int N_COLS = 16,
  parameter int OUT_W  = 8
);
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  logic                    out_valid;
  logic                    out_ready;
  logic [ROW_W-1:0]        out_row;
  logic [N_COLS*OUT_W-1:0] out_data;
  logic                    out_last;

  modport master (output out_valid, output out_row, output out_data, output out_last,
                  input out_ready);
  modport slave  (input out_valid, input out_row, input out_data, input out_last,
                  output out_ready);
endinterface

// File: rtl/systolic_result_drain.sv
// Snapshots the accumulator matrix, requantizes to int8 and streams one row per beat.
// Optional macro DRAIN_RELU_EN clamps negative results to zero before saturation.
module systolic_result_drain #(
  parameter int N_ROWS  = 16,
  parameter int N_COLS  = 16,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_ROWS*N_COLS*ACC_W-1:0] i_c_in_flat,
  input  logic                           i_capture,
  input  logic [SHIFT_W-1:0]             i_shift_amt,
  output logic                           o_busy,
  output logic                           o_done,
  systolic_result_drain_if.master        out_if
);
  localparam int ROW_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 <<< (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(1 <<< (OUT_W - 1)));

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

  state_t                  r_state;
  state_t                  w_nextState;
  logic [ROW_W-1:0]        r_rowPtr;
  logic [SHIFT_W-1:0]      r_shift;
  logic signed [ACC_W-1:0] r_snap [N_ROWS][N_COLS];
  logic [N_COLS*OUT_W-1:0] w_rowData;
  logic                    w_accept;
  logic                    w_fire;
  logic                    w_rowLast;

  // Rounding term is added one bit wider than the accumulator so it never overflows.
  function automatic logic [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc,
                                               input logic [SHIFT_W-1:0] s);
    logic signed [ACC_W:0] rnd;
    logic signed [ACC_W:0] t;
    logic signed [ACC_W:0] y;
    logic [OUT_W-1:0]      res;
    rnd = '0;
    if (s != '0) rnd = (ACC_W+1)'(1) << (s - 1'b1);
    t = (ACC_W+1)'(acc) + rnd;
    y = t >>> s;
`ifdef DRAIN_RELU_EN
    if (y[ACC_W])         res = '0;
    else if (y > SAT_MAX) res = SAT_MAX[OUT_W-1:0];
    else                  res = y[OUT_W-1:0];
`else
    if (y > SAT_MAX)      res = SAT_MAX[OUT_W-1:0];
    else if (y < SAT_MIN) res = SAT_MIN[OUT_W-1:0];
    else                  res = y[OUT_W-1:0];
`endif
    return res;
  endfunction

  assign w_accept  = (r_state == IDLE) && i_capture;
  assign w_fire    = (r_state == DRAIN) && out_if.out_ready;
  assign w_rowLast = (r_rowPtr == LAST_ROW);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // The snapshot bank decouples the array from the drain so the next tile can start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rowPtr <= '0;
      r_shift  <= '0;
      for (int r = 0; r < N_ROWS; r++)
        for (int c = 0; c < N_COLS; c++)
          r_snap[r][c] <= '0;
    end else if (w_accept) begin
      r_rowPtr <= '0;
      r_shift  <= i_shift_amt;
      for (int r = 0; r < N_ROWS; r++)
        for (int c = 0; c < N_COLS; c++)
          r_snap[r][c] <= i_c_in_flat[(r*N_COLS + c)*ACC_W +: ACC_W];
    end else if (w_fire && !w_rowLast) begin
      r_rowPtr <= r_rowPtr + 1'b1;
    end
  end

  always_comb begin
    w_rowData = '0;
    for (int c = 0; c < N_COLS; c++)
      w_rowData[c*OUT_W +: OUT_W] = requant(r_snap[r_rowPtr][c], r_shift);
  end

  // Beat fields are forced to zero outside DRAIN so idle and reset outputs read as zero.
  always_comb begin
    w_nextState      = r_state;
    o_busy           = 1'b0;
    o_done           = 1'b0;
    out_if.out_valid = 1'b0;
    out_if.out_row   = '0;
    out_if.out_data  = '0;
    out_if.out_last  = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_capture) w_nextState = DRAIN;
      end
      DRAIN: begin
        o_busy           = 1'b1;
        out_if.out_valid = 1'b1;
        out_if.out_row   = r_rowPtr;
        out_if.out_data  = w_rowData;
        out_if.out_last  = w_rowLast;
        if (out_if.out_ready && w_rowLast) w_nextState = DONE;
      end
      DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end
endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: reset, full drain, requant corners,
// backpressure, snapshot isolation and reset abort.
module tb_systolic_result_drain;
  localparam int NR = 16;
  localparam int NC = 16;
  localparam int AW = 32;
  localparam int OW = 8;
  localparam int SW = 5;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NR*NC*AW-1:0]    cIn;
  logic                   capture;
  logic [SW-1:0]          shiftAmt;
  logic                   busy;
  logic                   done;
  int                     nCompared = 0;
  int                     nMismatched = 0;
  logic [NC*OW-1:0]       e;

  systolic_result_drain_if #(.N_ROWS(NR), .N_COLS(NC), .OUT_W(OW)) drainIf ();

  systolic_result_drain #(.N_ROWS(NR), .N_COLS(NC), .ACC_W(AW), .OUT_W(OW), .SHIFT_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .i_c_in_flat(cIn), .i_capture(capture),
    .i_shift_amt(shiftAmt), .o_busy(busy), .o_done(done), .out_if(drainIf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic cap, input logic [SW-1:0] sh, input logic rdy);
    capture          = cap;
    shiftAmt         = sh;
    drainIf.out_ready = rdy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setAcc(input int r, input int c, input logic [31:0] v);
    cIn[(r*NC + c)*AW +: AW] = v;
  endtask

  task automatic fillAll(input logic [31:0] v);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) setAcc(r, c, v);
  endtask

  function automatic logic [127:0] rampRow(input int r);
    logic [127:0] x;
    x = '0;
    for (int c = 0; c < NC; c++) x[c*8 +: 8] = 8'((r*16 + c > 127) ? 127 : r*16 + c);
    return x;
  endfunction

  function automatic logic [127:0] sumRow(input int r);
    logic [127:0] x;
    x = '0;
    for (int c = 0; c < NC; c++) x[c*8 +: 8] = 8'(r + c);
    return x;
  endfunction

  function automatic logic [127:0] fillRow(input logic [7:0] b);
    logic [127:0] x;
    for (int c = 0; c < NC; c++) x[c*8 +: 8] = b;
    return x;
  endfunction

  task automatic loadRamp();
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) setAcc(r, c, 32'(r*16 + c));
  endtask

  task automatic finishDrain(input string tag);
    logic seen;
    seen = 1'b0;
    drainIf.out_ready = 1'b1;
    capture = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done === 1'b1) seen = 1'b1;
      else tick();
    end
    checkOutput(tag, seen, 1);
    tick();
  endtask

  task automatic doTile(input logic [SW-1:0] sh, input logic [127:0] exp, input string tag);
    applyStimulus(1'b1, sh, 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput({tag, " row0"}, drainIf.out_data, exp);
    finishDrain({tag, " done"});
  endtask

  initial begin
    logic doneSeen;
    logic anyValid;
    logic anyDone;
    logic rdy;
    int   expRow;
    int   beats;

    // Reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < NR*NC; i++) cIn[i*AW +: AW] = $urandom();
    applyStimulus(1'b1, SW'($urandom_range(0, 31)), 1'b1);
    tick();
    tick();
    checkOutput("rst busy", busy, 0);
    checkOutput("rst valid", drainIf.out_valid, 0);
    checkOutput("rst row", drainIf.out_row, 0);
    checkOutput("rst data", drainIf.out_data, 0);
    checkOutput("rst last", drainIf.out_last, 0);
    checkOutput("rst done", done, 0);
    applyStimulus(1'b0, '0, 1'b1);
    rst_n = 1'b1;
    tick();
    tick();
    checkOutput("post-rst busy", busy, 0);
    checkOutput("post-rst valid", drainIf.out_valid, 0);
    checkOutput("post-rst data", drainIf.out_data, 0);

    // Full drain, ramp data, shift 0
    cIn = '0;
    loadRamp();
    applyStimulus(1'b1, 5'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1);
    for (int r = 0; r < NR; r++) begin
      checkOutput($sformatf("drain valid r%0d", r), drainIf.out_valid, 1);
      checkOutput($sformatf("drain row r%0d", r), drainIf.out_row, r);
      checkOutput($sformatf("drain last r%0d", r), drainIf.out_last, (r == NR-1) ? 1 : 0);
      checkOutput($sformatf("drain data r%0d", r), drainIf.out_data, rampRow(r));
      checkOutput($sformatf("drain done r%0d", r), done, 0);
      tick();
    end
    checkOutput("drain done pulse", done, 1);
    checkOutput("drain done valid", drainIf.out_valid, 0);
    checkOutput("drain done busy", busy, 1);
    tick();
    checkOutput("drain idle done", done, 0);
    checkOutput("drain idle busy", busy, 0);

    // Rounding and saturation corners
    cIn = '0;
    setAcc(0, 0, 32'sd5); setAcc(0, 1, -32'sd5); setAcc(0, 2, 32'sd1); setAcc(0, 3, -32'sd1);
    e = '0; e[7:0] = 8'h03; e[15:8] = 8'hFE; e[23:16] = 8'h01; e[31:24] = 8'h00;
`ifdef DRAIN_RELU_EN
    e[15:8] = 8'h00;
`endif
    doTile(5'd1, e, "shift1");

    cIn = '0;
    setAcc(0, 0, 32'sd1000); setAcc(0, 1, 32'sd6); setAcc(0, 2, -32'sd1000);
    e = '0; e[7:0] = 8'h7F; e[15:8] = 8'h02; e[23:16] = 8'h80;
`ifdef DRAIN_RELU_EN
    e[23:16] = 8'h00;
`endif
    doTile(5'd2, e, "shift2");

    cIn = '0;
    setAcc(0, 0, -32'sd100000); setAcc(0, 1, -32'sd300); setAcc(0, 2, -32'sd5); setAcc(0, 3, 32'sd100);
`ifdef DRAIN_RELU_EN
    e = '0; e[31:24] = 8'h64;
`else
    e = '0; e[7:0] = 8'h80; e[15:8] = 8'h80; e[23:16] = 8'hFB; e[31:24] = 8'h64;
`endif
    doTile(5'd0, e, "shift0");

    cIn = '0;
    setAcc(0, 0, 32'h7FFFFFFF); setAcc(0, 1, 32'h80000000);
    e = '0; e[7:0] = 8'h01; e[15:8] = 8'hFF;
`ifdef DRAIN_RELU_EN
    e[15:8] = 8'h00;
`endif
    doTile(5'd31, e, "shift31");

    // Backpressure with pseudo-random ready
    cIn = '0;
    loadRamp();
    applyStimulus(1'b1, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b0);
    expRow = 0;
    beats = 0;
    doneSeen = 1'b0;
    for (int cyc = 0; cyc < 300 && !doneSeen; cyc++) begin
      if (done === 1'b1) begin
        doneSeen = 1'b1;
      end else begin
        checkOutput("bp valid", drainIf.out_valid, 1);
        checkOutput($sformatf("bp row e%0d", expRow), drainIf.out_row, expRow);
        checkOutput($sformatf("bp data e%0d", expRow), drainIf.out_data, rampRow(expRow));
        checkOutput($sformatf("bp last e%0d", expRow), drainIf.out_last, (expRow == NR-1) ? 1 : 0);
        rdy = 1'($urandom_range(0, 1));
        drainIf.out_ready = rdy;
        if (rdy) begin
          beats++;
          expRow++;
        end
        tick();
      end
    end
    checkOutput("bp done seen", doneSeen, 1);
    checkOutput("bp beat count", beats, NR);
    tick();

    // Snapshot isolation: input changes and capture pulses during drain are ignored
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) setAcc(r, c, 32'(r + c));
    applyStimulus(1'b1, 5'd0, 1'b1);
    tick();
    fillAll(32'd50);
    for (int r = 0; r < NR; r++) begin
      checkOutput($sformatf("iso row r%0d", r), drainIf.out_row, r);
      checkOutput($sformatf("iso data r%0d", r), drainIf.out_data, sumRow(r));
      tick();
    end
    checkOutput("iso done", done, 1);
    tick();
    checkOutput("iso idle valid", drainIf.out_valid, 0);
    checkOutput("iso idle busy", busy, 0);
    applyStimulus(1'b0, 5'd0, 1'b1);
    tick();
    tick();
    checkOutput("iso no redrain", drainIf.out_valid, 0);
    applyStimulus(1'b1, 5'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1);
    checkOutput("iso recap row", drainIf.out_row, 0);
    checkOutput("iso recap data", drainIf.out_data, fillRow(8'd50));
    finishDrain("iso recap done");

    // Reset at row 7 aborts the tile
    loadRamp();
    applyStimulus(1'b1, 5'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1);
    repeat (7) tick();
    checkOutput("abort at row7", drainIf.out_row, 7);
    rst_n = 1'b0;
    #1;
    checkOutput("abort valid", drainIf.out_valid, 0);
    checkOutput("abort busy", busy, 0);
    checkOutput("abort row", drainIf.out_row, 0);
    checkOutput("abort data", drainIf.out_data, 0);
    checkOutput("abort last", drainIf.out_last, 0);
    tick();
    tick();
    rst_n = 1'b1;
    anyValid = 1'b0;
    anyDone = 1'b0;
    for (int i = 0; i < 10; i++) begin
      anyValid |= drainIf.out_valid;
      anyDone  |= done;
      tick();
    end
    checkOutput("abort no valid", anyValid, 0);
    checkOutput("abort no done", anyDone, 0);
    fillAll(32'hFFFFFFFD);
    applyStimulus(1'b1, 5'd0, 1'b1);
    tick();
    applyStimulus(1'b0, 5'd0, 1'b1);
    checkOutput("restart valid", drainIf.out_valid, 1);
    checkOutput("restart row", drainIf.out_row, 0);
`ifdef DRAIN_RELU_EN
    checkOutput("restart data", drainIf.out_data, fillRow(8'h00));
`else
    checkOutput("restart data", drainIf.out_data, fillRow(8'hFD));
`endif
    finishDrain("restart done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule
